// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing scheduler.
package mul_share_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Requester ID width; a single-requester build still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_share_sched_if.sv
// Request, response and core-launch signals of the multiplier-sharing scheduler.
interface mul_share_sched_if
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ID_W    = id_width(NUM_REQ)
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [2*WIDTH-1:0]       rsp_product;
   logic                     rsp_err;

   logic                     mul_start;
   logic [WIDTH-1:0]         mul_a;
   logic [WIDTH-1:0]         mul_b;
   logic                     mul_done;
   logic [2*WIDTH-1:0]       mul_product;

   logic                     busy;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
      output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
             mul_start, mul_a, mul_b, busy
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_done, mul_product,
      input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
             mul_start, mul_a, mul_b, busy
   );

endinterface

// File: rtl/mul_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic [ID_W:0]   sum  [NUM_REQ];
   logic [ID_W-1:0] cand [NUM_REQ];
   logic            found;

   // cand[k] is the requester examined k-th, i.e. (ptr + k) mod NUM_REQ.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign sum[gi]  = {1'b0, ptr} + (ID_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (ID_W+1)'(NUM_REQ)) ?
                        ID_W'(sum[gi] - (ID_W+1)'(NUM_REQ)) : sum[gi][ID_W-1:0];
   end

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[cand[k]]) begin
            found           = 1'b1;
            grant_idx       = cand[k];
            grant[cand[k]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one sequential multiplier core among NUM_REQ requesters with
// round-robin arbitration, a launch pulse, done timeout and a tagged response.
module mul_share_sched
   import mul_share_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input logic              clk,
   input logic              reset,
   mul_share_sched_if.slave bus
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

   state_t               state_reg;
   state_t               state_next;
   logic [ID_W-1:0]      ptr_reg;
   logic [ID_W-1:0]      id_reg;
   logic [WIDTH-1:0]     a_reg;
   logic [WIDTH-1:0]     b_reg;
   logic [2*WIDTH-1:0]   prod_reg;
   logic                 err_reg;
   logic [CNT_W-1:0]     cnt_reg;

   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_idx;
   logic                 accept;
   logic                 timed_out;
   logic [WIDTH-1:0]     a_slice [NUM_REQ];
   logic [WIDTH-1:0]     b_slice [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = bus.req_b[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (bus.req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign accept    = (state_reg == IDLE) && (grant != '0);
   assign timed_out = (cnt_reg == CNT_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (bus.mul_done || timed_out) state_next = RESP;
         RESP:    if (bus.rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         id_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         prod_reg  <= '0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  a_reg  <= a_slice[grant_idx];
                  b_reg  <= b_slice[grant_idx];
                  id_reg <= grant_idx;
               end
            end
            ISSUE: cnt_reg <= '0;
            WAIT: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               // A done arriving on the timeout cycle still delivers the real product.
               if (bus.mul_done) begin
                  prod_reg <= bus.mul_product;
                  err_reg  <= 1'b0;
               end else if (timed_out) begin
                  prod_reg <= '0;
                  err_reg  <= 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  ptr_reg <= (id_reg == ID_LAST) ? '0 : id_reg + ID_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready   = (state_reg == IDLE) ? grant : '0;
   assign bus.mul_start   = (state_reg == ISSUE);
   assign bus.mul_a       = a_reg;
   assign bus.mul_b       = b_reg;
   assign bus.rsp_valid   = (state_reg == RESP);
   assign bus.rsp_id      = id_reg;
   assign bus.rsp_product = prod_reg;
   assign bus.rsp_err     = err_reg;
   assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched with a behavioural multiplier core.
module tb_mul_share_sched;

   localparam int N    = 4;
   localparam int W    = 32;
   localparam int ID_W = 2;
   localparam int TO   = 64;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mul_share_sched_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(ID_W)) bus ();

   mul_share_sched #(
      .NUM_REQ (N),
      .WIDTH   (W),
      .TIMEOUT (TO),
      .ID_W    (ID_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [63:0]     prod;
      logic            err;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int core_lat = 3;
   int acc_cyc  = -10;
   int start_cyc = 0;
   int rise_cyc  = 0;

   int               issued   [N];
   int               accepted [N];
   logic signed [W-1:0] op_a [N];
   logic signed [W-1:0] op_b [N];
   logic [W-1:0]     exp_ma;
   logic [W-1:0]     exp_mb;

   int tbl_a [N] = '{3, 7, 100, -8};
   int tbl_b [N] = '{5, -2, 100, -9};
   longint tbl_p [N] = '{15, -14, 10000, 72};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=bound_expired required=event", name);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input int r, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
      op_a[r] = a;
      op_b[r] = b;
      issued[r]++;
   endtask

   task automatic expect_rsp(input int id, input longint p, input logic err);
      exp_t e;
      e.id   = ID_W'(id);
      e.prod = p;
      e.err  = err;
      sb.push_back(e);
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (issued[i] != accepted[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((pending() || sb.size() != 0 || bus.busy) && n < budget) begin
         tick(1);
         n++;
      end
      if (n >= budget) bound_fail("drain");
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},        64'(bus.busy), 0);
      chk({tag, "_rsp_valid"},   64'(bus.rsp_valid), 0);
      chk({tag, "_rsp_id"},      64'(bus.rsp_id), 0);
      chk({tag, "_rsp_product"}, bus.rsp_product, 0);
      chk({tag, "_rsp_err"},     64'(bus.rsp_err), 0);
      chk({tag, "_mul_start"},   64'(bus.mul_start), 0);
      chk({tag, "_mul_a"},       64'(bus.mul_a), 0);
      chk({tag, "_mul_b"},       64'(bus.mul_b), 0);
      chk({tag, "_req_ready"},   64'(bus.req_ready), 0);
   endtask

   // Requester driver: valid held until the handshake it sees mid-cycle.
   initial begin : driver
      logic [N-1:0] hs;
      for (int i = 0; i < N; i++) accepted[i] = 0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      forever begin
         @(negedge clk);
         hs = reset ? (bus.req_valid & bus.req_ready) : '0;
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            if (hs[i]) accepted[i]++;
            bus.req_valid[i]     = (issued[i] != accepted[i]);
            bus.req_a[i*W +: W]  = op_a[i];
            bus.req_b[i*W +: W]  = op_b[i];
         end
      end
   end

   // Multiplier core model: done pulse core_lat cycles after start; core_lat<0 never finishes.
   initial begin : core
      logic signed [W-1:0] ca;
      logic signed [W-1:0] cb;
      int lat;
      bus.mul_done    = 1'b0;
      bus.mul_product = '0;
      forever begin
         @(negedge clk);
         if (bus.mul_start && reset) begin
            ca  = bus.mul_a;
            cb  = bus.mul_b;
            lat = core_lat;
            if (lat > 0) begin
               repeat (lat) @(posedge clk);
               #1;
               bus.mul_done    = 1'b1;
               bus.mul_product = longint'(ca) * longint'(cb);
               @(posedge clk);
               #1;
               bus.mul_done    = 1'b0;
            end
         end
      end
   end

   initial begin : monitor
      logic prev_start;
      logic prev_rv;
      logic [N-1:0] hs;
      exp_t e;
      prev_start = 1'b0;
      prev_rv    = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            if (bus.busy) chk("ready_outside_idle", 64'(bus.req_ready), 0);
            hs = bus.req_valid & bus.req_ready;
            if (hs != '0) begin
               acc_cyc = cyc;
               for (int i = 0; i < N; i++) begin
                  if (hs[i]) begin
                     exp_ma = op_a[i];
                     exp_mb = op_b[i];
                  end
               end
            end
            if (bus.mul_start) begin
               chk("start_after_accept", 64'(cyc - acc_cyc), 1);
               chk("start_single_cycle", 64'(prev_start), 0);
               chk("mul_a", 64'(bus.mul_a), 64'(exp_ma));
               chk("mul_b", 64'(bus.mul_b), 64'(exp_mb));
               start_cyc = cyc;
            end
            if (bus.rsp_valid && !prev_rv) rise_cyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_rsp actual_id=%0d actual_product=%0h required=none",
                           bus.rsp_id, bus.rsp_product);
               end else begin
                  e = sb.pop_front();
                  chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                  chk("rsp_product", bus.rsp_product, e.prod);
                  chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                  $display("rsp id=%0d product=%0d err=%0d", bus.rsp_id,
                           $signed(bus.rsp_product), bus.rsp_err);
               end
            end
            prev_start = bus.mul_start;
            prev_rv    = bus.rsp_valid;
         end else begin
            prev_start = 1'b0;
            prev_rv    = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      for (int i = 0; i < N; i++) begin
         issued[i] = 0;
         op_a[i]   = '0;
         op_b[i]   = '0;
      end
      bus.rsp_ready = 1'b1;
      reset = 1'b0;
      tick(3);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1;

      // All requesters valid from reset release: served 0,1,2,3.
      for (int i = 0; i < N; i++) begin
         issue(i, tbl_a[i], tbl_b[i]);
         expect_rsp(i, tbl_p[i], 1'b0);
      end
      tick(1);
      reset = 1'b1;
      wait_drain(400);

      // Only 0 and 2 valid: served 0,2.
      issue(0, tbl_a[0], tbl_b[0]);
      issue(2, tbl_a[2], tbl_b[2]);
      expect_rsp(0, tbl_p[0], 1'b0);
      expect_rsp(2, tbl_p[2], 1'b0);
      wait_drain(200);

      // Single request from requester 1 with a 34-cycle core.
      core_lat = 34;
      issue(1, 553524, 840);
      expect_rsp(1, 464960160, 1'b0);
      wait_drain(200);
      chk("lat34_rsp_cycle", 64'(rise_cyc - start_cyc), 35);

      // Signed operands.
      core_lat = 5;
      issue(0, -259, -259);
      expect_rsp(0, 67081, 1'b0);
      wait_drain(200);
      issue(0, -259, 553524);
      expect_rsp(0, -143362716, 1'b0);
      wait_drain(200);

      // Backpressure: response held 5 cycles while requester 2 waits.
      core_lat = 4;
      bus.rsp_ready = 1'b0;
      issue(3, -8, -9);
      expect_rsp(3, 72, 1'b0);
      n = 0;
      while (accepted[3] != issued[3] && n < 20) begin
         tick(1);
         n++;
      end
      if (n >= 20) bound_fail("bp_accept");
      issue(2, 100, 100);
      expect_rsp(2, 10000, 1'b0);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) bound_fail("bp_rsp_valid");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 64'(bus.rsp_valid), 1);
         chk("bp_id", 64'(bus.rsp_id), 3);
         chk("bp_product", bus.rsp_product, 72);
         chk("bp_no_ready", 64'(bus.req_ready), 0);
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_next_grant", 64'(bus.req_ready), 64'(4'b0100));
      @(posedge clk);
      #1;
      wait_drain(200);

      // Timeout: core never finishes, then done exactly on the last WAIT cycle.
      core_lat = -1;
      issue(0, 11, 13);
      expect_rsp(0, 0, 1'b1);
      wait_drain(400);
      chk("timeout_rsp_cycle", 64'(rise_cyc - start_cyc), 65);
      core_lat = 64;
      issue(1, 11, 13);
      expect_rsp(1, 143, 1'b0);
      wait_drain(400);
      chk("done_at_limit_rsp_cycle", 64'(rise_cyc - start_cyc), 65);

      // Reset during WAIT, stale done afterwards, pointer back to requester 0.
      core_lat = 20;
      issue(1, 5, 6);
      n = 0;
      while (!bus.mul_start && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) bound_fail("reset_test_start");
      tick(3);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_reset");
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         chk("stale_done_ignored", 64'(bus.rsp_valid), 0);
      end
      @(posedge clk);
      #1;
      core_lat = 3;
      issue(0, tbl_a[0], tbl_b[0]);
      issue(3, tbl_a[3], tbl_b[3]);
      expect_rsp(0, tbl_p[0], 1'b0);
      expect_rsp(3, tbl_p[3], 1'b0);
      wait_drain(200);

      chk("scoreboard_empty", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
